// File: rtl/calc_pkg.sv
// Shared opcodes, state encoding and decimal helpers for the calculator core.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_EQ  = 2'd2;
    localparam logic [1:0] OP_CLR = 2'd3;

    typedef enum logic [1:0] {
        ST_ENTRY_A = 2'd0,
        ST_ENTRY_B = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int MUL_W = 32;

    function automatic logic [MUL_W+3:0] mul10_add(input logic [MUL_W-1:0] value,
                                                   input logic [3:0] digit);
        logic [MUL_W+3:0] wide;
        wide = {4'b0000, value};
        return (wide * 36'd10) + {32'd0, digit};
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/decimal_entry_reg.sv
// One decimal operand register: shifts in digits until MAX_DIGITS are held.
module decimal_entry_reg
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [CW-1:0]    load_count,
    input  logic             push,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] next_value;

    assign full       = (count == CW'(MAX_DIGITS));
    assign next_value = WIDTH'(mul10_add(MUL_W'(value), digit));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            count <= load_count;
        end else if (push && !full) begin
            value <= next_value;
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/calc_accumulator.sv
// Decimal calculator core: two keyed operands, latched ADD/SUB, result on EQUALS
// with chaining from DONE.
module calc_accumulator
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4,
    parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       digit,
    input  logic             digit_valid,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    output logic [WIDTH-1:0] display,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             negative,
    output logic             overflow,
    output logic             error,
    output logic [1:0]       state,
    output logic [CW-1:0]    digit_count
);

    localparam longint unsigned MAX_VALUE = pow10(MAX_DIGITS) - 64'd1;

    if (WIDTH > MUL_W || MAX_VALUE >= (64'd1 << WIDTH)) begin : g_bad_params
        $error("calc_accumulator: MAX_DIGITS decimal digits do not fit in WIDTH bits");
    end

    state_t           state_q, state_d;
    logic             op_sub_q;
    logic             a_clear, a_load, a_push, b_clear, b_push;
    logic [WIDTH-1:0] a_load_value;
    logic [CW-1:0]    a_load_count;
    logic             a_full, b_full;
    logic [CW-1:0]    a_count, b_count;
    logic             set_result, neg_d, ovf_set, err_d, op_latch, clear_all, new_calc;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH:0]   sum;
    logic             digit_ok;

    assign sum      = {1'b0, operand_a} + {1'b0, operand_b};
    assign digit_ok = (digit <= 4'd9);

    decimal_entry_reg #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_reg_a (
        .clock(clock), .reset(reset), .clear(a_clear), .load(a_load),
        .load_value(a_load_value), .load_count(a_load_count),
        .push(a_push), .digit(digit), .value(operand_a), .count(a_count), .full(a_full)
    );

    decimal_entry_reg #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_reg_b (
        .clock(clock), .reset(reset), .clear(b_clear), .load(1'b0),
        .load_value('0), .load_count('0),
        .push(b_push), .digit(digit), .value(operand_b), .count(b_count), .full(b_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_ENTRY_A;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (op_valid) begin
            case (op_code)
                OP_CLR:  state_d = ST_ENTRY_A;
                OP_EQ:   if (state_q != ST_DONE) state_d = ST_DONE;
                default: if (state_q == ST_ENTRY_A || (state_q == ST_DONE && !negative))
                             state_d = ST_ENTRY_B;
            endcase
        end else if (digit_valid && digit_ok && state_q == ST_DONE) begin
            state_d = ST_ENTRY_A;
        end
    end

    always_comb begin
        a_clear = 1'b0; a_load = 1'b0; a_push = 1'b0; b_clear = 1'b0; b_push = 1'b0;
        a_load_value = '0; a_load_count = '0;
        set_result = 1'b0; result_d = '0; neg_d = 1'b0; ovf_set = 1'b0;
        err_d = 1'b0; op_latch = 1'b0; clear_all = 1'b0; new_calc = 1'b0;
        if (op_valid) begin
            // a digit arriving together with an op is always dropped
            err_d = digit_valid;
            case (op_code)
                OP_CLR: begin
                    a_clear = 1'b1; b_clear = 1'b1; clear_all = 1'b1;
                end
                OP_EQ: begin
                    if (state_q == ST_ENTRY_A) begin
                        set_result = 1'b1; result_d = operand_a;
                    end else if (state_q == ST_ENTRY_B) begin
                        set_result = 1'b1;
                        if (!op_sub_q) begin
                            result_d = sum[WIDTH-1:0]; ovf_set = sum[WIDTH];
                        end else if (operand_a >= operand_b) begin
                            result_d = operand_a - operand_b;
                        end else begin
                            result_d = operand_b - operand_a; neg_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (state_q == ST_ENTRY_A) begin
                        op_latch = 1'b1; b_clear = 1'b1;
                    end else if (state_q == ST_ENTRY_B) begin
                        if (b_count == '0) op_latch = 1'b1;
                        else               err_d = 1'b1;
                    end else if (!negative) begin
                        a_load = 1'b1; a_load_value = result; b_clear = 1'b1; op_latch = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (digit_valid) begin
            if (!digit_ok) begin
                err_d = 1'b1;
            end else if (state_q == ST_DONE) begin
                a_load = 1'b1; a_load_value = WIDTH'(digit); a_load_count = CW'(1);
                b_clear = 1'b1; new_calc = 1'b1;
            end else if (state_q == ST_ENTRY_A) begin
                a_push = 1'b1; ovf_set = a_full;
            end else begin
                b_push = 1'b1; ovf_set = b_full;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0; result_valid <= 1'b0; negative <= 1'b0;
            overflow <= 1'b0; error <= 1'b0; op_sub_q <= 1'b0;
        end else begin
            result_valid <= set_result;
            error        <= err_d;
            if (clear_all) begin
                result <= '0; negative <= 1'b0; overflow <= 1'b0; op_sub_q <= 1'b0;
            end else begin
                if (set_result) begin
                    result   <= result_d;
                    negative <= neg_d;
                end else if (new_calc) begin
                    negative <= 1'b0;
                end
                if (new_calc)     overflow <= 1'b0;
                else if (ovf_set) overflow <= 1'b1;
                if (op_latch)     op_sub_q <= (op_code == OP_SUB);
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_ENTRY_A: display = operand_a;
            ST_ENTRY_B: display = operand_b;
            default:    display = result;
        endcase
    end

    assign digit_count = (state_q == ST_ENTRY_B) ? b_count : a_count;
    assign state       = state_q;

endmodule

// File: tb/tb_calc_accumulator.sv
// Scoreboard bench for calc_accumulator: directed key sequences plus random keying
// against an integer reference model of the calculator.
module tb_calc_accumulator;

    localparam int WIDTH = 16;
    localparam int MAXD  = 4;
    localparam int CW    = 3;
    localparam int MODV  = 65536;

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0]       digit;
    logic             digit_valid, op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] display, operand_a, operand_b, result;
    logic             result_valid, negative, overflow, error;
    logic [1:0]       state;
    logic [CW-1:0]    digit_count;

    calc_accumulator #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD), .CW(CW)) dut (
        .clock(clock), .reset(reset), .digit(digit), .digit_valid(digit_valid),
        .op_valid(op_valid), .op_code(op_code), .display(display),
        .operand_a(operand_a), .operand_b(operand_b), .result(result),
        .result_valid(result_valid), .negative(negative), .overflow(overflow),
        .error(error), .state(state), .digit_count(digit_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct { int res; int neg; } exp_t;
    exp_t sb[$];

    // reference calculator: mode 0 = entering A, 1 = entering B, 2 = showing result
    int m_mode, m_a, m_b, m_res, m_neg, m_ovf, m_cnt, m_sub, m_err, m_rv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_mode = 0; m_a = 0; m_b = 0; m_res = 0; m_neg = 0;
        m_ovf = 0; m_cnt = 0; m_sub = 0; m_err = 0; m_rv = 0;
    endtask

    task automatic model_step(input bit dv, input int d, input bit ov, input int oc);
        m_err = 0; m_rv = 0;
        if (ov) begin
            if (oc == 3) model_clear();
            else if (oc == 2) begin
                if (m_mode == 0) begin
                    m_res = m_a; m_neg = 0; m_rv = 1; m_mode = 2;
                end else if (m_mode == 1) begin
                    if (!m_sub) begin
                        if (m_a + m_b >= MODV) m_ovf = 1;
                        m_res = (m_a + m_b) % MODV; m_neg = 0;
                    end else if (m_a >= m_b) begin
                        m_res = m_a - m_b; m_neg = 0;
                    end else begin
                        m_res = m_b - m_a; m_neg = 1;
                    end
                    m_rv = 1; m_mode = 2;
                end
            end else begin
                if (m_mode == 0) begin
                    m_sub = oc; m_b = 0; m_cnt = 0; m_mode = 1;
                end else if (m_mode == 1) begin
                    if (m_cnt == 0) m_sub = oc;
                    else m_err = 1;
                end else if (m_neg == 0) begin
                    m_a = m_res; m_b = 0; m_cnt = 0; m_sub = oc; m_mode = 1;
                end else m_err = 1;
            end
            if (dv) m_err = 1;
        end else if (dv) begin
            if (d > 9) m_err = 1;
            else if (m_mode == 2) begin
                m_a = d; m_b = 0; m_neg = 0; m_ovf = 0; m_cnt = 1; m_mode = 0;
            end else if (m_cnt == MAXD) m_ovf = 1;
            else begin
                if (m_mode == 0) m_a = (m_a * 10 + d) % MODV;
                else             m_b = (m_b * 10 + d) % MODV;
                m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        int exp_disp;
        exp_disp = (m_mode == 0) ? m_a : (m_mode == 1) ? m_b : m_res;
        chk("state", int'(state), m_mode);
        chk("operand_a", int'(operand_a), m_a);
        chk("operand_b", int'(operand_b), m_b);
        chk("display", int'(display), exp_disp);
        if (m_mode != 2) chk("digit_count", int'(digit_count), m_cnt);
        chk("overflow", int'(overflow), m_ovf);
        chk("negative", int'(negative), m_neg);
        chk("error", int'(error), m_err);
        chk("result_valid", int'(result_valid), m_rv);
        chk("result", int'(result), m_res);
    endtask

    task automatic step(input bit dv, input int d, input bit ov, input int oc);
        exp_t e;
        @(negedge clock);
        digit_valid = dv; digit = 4'(d); op_valid = ov; op_code = 2'(oc);
        @(posedge clock);
        #1;
        digit_valid = 1'b0; op_valid = 1'b0;
        model_step(dv, d, ov, oc);
        if (m_rv) begin
            e.res = m_res; e.neg = m_neg;
            sb.push_back(e);
        end
        check_all();
    endtask

    task automatic num(input int v);
        int ds[$];
        int t;
        t = v;
        if (t == 0) ds.push_front(0);
        while (t > 0) begin
            ds.push_front(t % 10);
            t = t / 10;
        end
        foreach (ds[i]) step(1'b1, ds[i], 1'b0, 0);
    endtask

    task automatic op(input int oc);
        step(1'b0, 0, 1'b1, oc);
    endtask

    always @(negedge clock) begin
        if (!reset && result_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_spurious_result actual=%0d required=no pulse", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", int'(result), e.res);
                chk("sb_negative", int'(negative), e.neg);
            end
        end
    end

    initial begin
        digit = '0; digit_valid = 1'b0; op_valid = 1'b0; op_code = '0;
        reset = 1'b1;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b0;

        num(46); op(0); num(327); op(2);
        chk("tp_add_373", int'(result), 373);
        step(1'b0, 0, 1'b0, 0);
        chk("tp_rv_one_cycle", int'(result_valid), 0);
        op(0); num(5); op(2);
        chk("tp_chain_378", int'(result), 378);

        num(99999);
        chk("tp_sat_a", int'(operand_a), 9999);
        chk("tp_sat_ovf", int'(overflow), 1);
        op(0); num(9999); op(2);
        chk("tp_sum_19998", int'(result), 19998);
        num(7);
        chk("tp_new_calc_ovf", int'(overflow), 0);
        chk("tp_new_calc_a", int'(operand_a), 7);

        op(3); num(12); op(1); num(45); op(2);
        chk("tp_sub_33", int'(result), 33);
        chk("tp_sub_neg", int'(negative), 1);
        op(0);
        chk("tp_chain_neg_err", int'(error), 1);
        chk("tp_chain_neg_state", int'(state), 2);

        op(3); num(50); op(0); op(1); num(8); op(2);
        chk("tp_op_replace", int'(result), 42);
        op(3); num(5); op(0); num(3); op(1);
        chk("tp_op_late_err", int'(error), 1);

        op(3); num(9999); op(2);
        for (int i = 0; i < 6; i++) begin
            op(0); num(9999); op(2);
        end
        chk("tp_carry_result", int'(result), 69993 - MODV);
        chk("tp_carry_ovf", int'(overflow), 1);

        op(3); num(31); step(1'b1, 12, 1'b0, 0);
        chk("tp_bad_digit_a", int'(operand_a), 31);
        step(1'b1, 4, 1'b1, 0);
        chk("tp_both_state", int'(state), 1);

        op(3); num(46);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_a", int'(operand_a), 0);
        chk("async_state", int'(state), 0);
        chk("async_count", int'(digit_count), 0);
        chk("async_display", int'(display), 0);
        reset = 1'b0;
        model_clear();

        num(46); op(0); num(1); op(2); num(46); op(3);
        chk("clear_result", int'(result), 0);

        for (int n = 0; n < 700; n++) begin
            int r, x;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                x = ($urandom_range(0, 99) < 5) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                step(1'b1, x, 1'b0, 0);
            end else begin
                x = $urandom_range(0, 99);
                x = (x < 35) ? 0 : (x < 65) ? 1 : (x < 96) ? 2 : 3;
                step(r >= 92, $urandom_range(0, 9), 1'b1, x);
            end
        end

        step(1'b0, 0, 1'b0, 0);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
